// File: rtl/cout_uart_pkg.sv
// cout_uart_pkg: transmitter state encoding, UART frame constants and FIFO pointer sizing
package cout_uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  localparam int DATA_BITS = 8;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/cout_uart_tx_if.sv
// cout_uart_tx_if: CPU result bus in, UART line and status out
interface cout_uart_tx_if #(parameter int DEPTH = 8);
  import cout_uart_pkg::*;
  logic [15:0] cout_in;
  logic txd;
  logic busy;
  logic overflow;
  logic [ptr_w(DEPTH)-1:0] fifo_count;
  modport master(output cout_in, input txd, busy, fifo_count, overflow);
  modport slave(input cout_in, output txd, busy, fifo_count, overflow);
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with wrap-bit pointers; pushes while full are ignored
module sync_fifo import cout_uart_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [ptr_w(DEPTH)-1:0]  count,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = ptr_w(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic wr, rd;
  assign count = wptr - rptr;
  assign full = count == PW'(DEPTH);
  assign empty = count == '0;
  assign wr = push && !full;
  assign rd = pop && !empty;
  assign dout = mem[rptr[PW-2:0]];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr) wptr <= wptr + PW'(1);
      if (rd) rptr <= rptr + PW'(1);
    end
  always_ff @(posedge clk)
    if (wr) mem[wptr[PW-2:0]] <= din;
endmodule

// File: rtl/cout_uart_tx.sv
// cout_uart_tx: captures every change of Cout into a FIFO and sends each word as two 8N1 bytes, high byte first
module cout_uart_tx import cout_uart_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input logic           clk,
  input logic           reset,
  cout_uart_tx_if.slave bus
);
  localparam int TW = $clog2(CLKS_PER_BIT);
  tx_state_e state;
  logic [15:0] last_cout, dout;
  logic [7:0] shreg, lo_byte;
  logic [TW-1:0] timer;
  logic [2:0] bitcnt;
  logic byte_idx, push_req, pop, full, empty, bit_end;
  assign push_req = bus.cout_in != last_cout;
  assign pop = state == IDLE && !empty;
  assign bit_end = timer == TW'(CLKS_PER_BIT - 1);
  sync_fifo #(.WIDTH(16), .DEPTH(DEPTH)) u_fifo (
    .clk, .reset, .push(push_req), .pop, .din(bus.cout_in), .dout,
    .count(bus.fifo_count), .full, .empty
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_cout <= '0;
      bus.overflow <= 1'b0;
    end else begin
      last_cout <= bus.cout_in;
      bus.overflow <= bus.overflow || (push_req && full);
    end
  // txd is only ever assigned here, so the line is a clean flop output
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      bus.txd <= STOP_BIT;
      bus.busy <= 1'b0;
      timer <= '0;
      bitcnt <= '0;
      byte_idx <= 1'b0;
      shreg <= '0;
      lo_byte <= '0;
    end else begin
      timer <= (state == IDLE || bit_end) ? '0 : timer + TW'(1);
      case (state)
        IDLE:
          if (!empty) begin
            state <= START;
            bus.busy <= 1'b1;
            bus.txd <= START_BIT;
            shreg <= dout[15:8];
            lo_byte <= dout[7:0];
            byte_idx <= 1'b0;
          end
        START:
          if (bit_end) begin
            state <= DATA;
            bus.txd <= shreg[0];
            bitcnt <= '0;
          end
        DATA:
          if (bit_end) begin
            if (bitcnt == 3'(DATA_BITS - 1)) begin
              state <= STOP;
              bus.txd <= STOP_BIT;
            end else begin
              bitcnt <= bitcnt + 3'd1;
              shreg <= {1'b0, shreg[7:1]};
              bus.txd <= shreg[1];
            end
          end
        STOP:
          if (bit_end) begin
            if (!byte_idx) begin
              state <= START;
              bus.txd <= START_BIT;
              shreg <= lo_byte;
              byte_idx <= 1'b1;
            end else begin
              state <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cout_uart_tx.sv
// tb_cout_uart_tx: random change bursts scored against a frame-decoding monitor
module tb_cout_uart_tx;
  localparam int DEPTH = 8;
  localparam int CPB = 4;
  localparam int WORD_CYC = 20 * CPB;
  typedef logic [15:0] wq_t[$];
  typedef struct {logic [15:0] w; int start;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  cout_uart_tx_if #(.DEPTH(DEPTH)) bus();
  cout_uart_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  exp_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0, words_seen = 0;
  logic ovf_exp = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
    end
  endtask

  // monitor: decode UART frames from txd, assemble words, compare with the scoreboard
  int mst = 0, mc = 0, nbyte = 0, wstart = 0;
  logic [7:0] sh, hi;
  exp_t e;
  always @(negedge clk) begin
    if (!reset) begin
      mst = 0;
      nbyte = 0;
    end else if (mst == 0) begin
      if (bus.txd == 1'b0) begin
        mst = 1;
        mc = 0;
        if (nbyte == 0) wstart = cyc;
        else check("low byte start offset", cyc - wstart, 10 * CPB);
      end
    end else begin
      mc++;
      if (mc == CPB / 2) check("start bit level", int'(bus.txd), 0);
      for (int i = 0; i < 8; i++)
        if (mc == CPB * (i + 1) + CPB / 2) sh[i] = bus.txd;
      if (mc == 9 * CPB + CPB / 2) begin
        check("stop bit level", int'(bus.txd), 1);
        mst = 0;
        if (nbyte == 0) begin
          hi = sh;
          nbyte = 1;
        end else begin
          nbyte = 0;
          words_seen++;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected word: got 0x%0h expected none", {hi, sh});
          end else begin
            e = exp_q.pop_front();
            check("word data", int'({hi, sh}), int'(e.w));
            check("word start cycle", wstart, e.start);
          end
        end
      end
    end
  end

  function automatic wq_t gen(input int n);
    wq_t q;
    logic [15:0] p = bus.cout_in, v;
    for (int i = 0; i < n; i++) begin
      do v = 16'($urandom_range(16, 65535)); while (v == p);
      q.push_back(v);
      p = v;
    end
    return q;
  endfunction

  // one change per cycle from an idle, empty DUT: the first word leaves at once,
  // so DEPTH+1 words are accepted and the rest are dropped
  task automatic drive_burst(input wq_t vals, output int c);
    int prev = 0, n = vals.size();
    @(posedge clk); #1;
    c = cyc;
    foreach (vals[i]) begin
      bus.cout_in = vals[i];
      if (i <= DEPTH) begin
        prev = (i == 0) ? c + 2 : prev + WORD_CYC + 1;
        exp_q.push_back('{w: vals[i], start: prev});
      end else ovf_exp = 1'b1;
      @(posedge clk); #1;
    end
    check("fifo_count after burst", int'(bus.fifo_count), n == 1 ? 1 : (n - 1 > DEPTH ? DEPTH : n - 1));
    check("overflow after burst", int'(bus.overflow), int'(ovf_exp));
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((exp_q.size() != 0 || bus.busy || bus.fifo_count != 0) && k < 4000) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain within budget", int'(k < 4000), 1);
    @(posedge clk); #1;
    check("idle txd", int'(bus.txd), 1);
    check("idle busy", int'(bus.busy), 0);
    check("idle fifo_count", int'(bus.fifo_count), 0);
    check("overflow sticky", int'(bus.overflow), int'(ovf_exp));
  endtask

  task automatic quiet_cycles(input string name, input int n);
    int lows = 0;
    repeat (n) begin
      @(negedge clk);
      if (!bus.txd || bus.busy) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin
    int c, w0;
    wq_t q;
    logic [19:0] pat = 20'b0010010001_0001011001;
    bus.cout_in = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("reset txd", int'(bus.txd), 1);
    check("reset busy", int'(bus.busy), 0);
    check("reset fifo_count", int'(bus.fifo_count), 0);
    check("reset overflow", int'(bus.overflow), 0);
    reset = 1'b1;
    quiet_cycles("no frame while cout holds 0", 20);

    q.delete();
    q.push_back(16'h1234);
    drive_burst(q, c);
    for (int b = 0; b < 20; b++) begin
      while (cyc != c + 2 + CPB * b + CPB / 2) @(negedge clk);
      check("0x1234 bit level", int'(bus.txd), int'(pat[19 - b]));
    end
    while (cyc != c + 1 + WORD_CYC) @(negedge clk);
    check("busy during last stop cycle", int'(bus.busy), 1);
    @(negedge clk);
    check("busy after last stop cycle", int'(bus.busy), 0);
    wait_drain();

    w0 = words_seen;
    q.delete();
    q.push_back(16'hBEEF);
    drive_burst(q, c);
    repeat (200) @(posedge clk);
    #1;
    check("steady input words", words_seen - w0, 1);
    wait_drain();

    drive_burst(gen(2), c);
    wait_drain();
    repeat (4) begin
      drive_burst(gen($urandom_range(1, DEPTH)), c);
      wait_drain();
    end

    q.delete();
    for (int i = 1; i <= 10; i++) q.push_back(16'(i));
    drive_burst(q, c);
    wait_drain();
    repeat (2) begin
      drive_burst(gen($urandom_range(DEPTH + 1, DEPTH + 4)), c);
      wait_drain();
    end

    drive_burst(gen(3), c);
    while (cyc < c + 2 + 3 * CPB) @(posedge clk);
    #1;
    reset = 1'b0;
    bus.cout_in = 16'h0000;
    #1;
    check("mid-frame reset txd", int'(bus.txd), 1);
    check("mid-frame reset busy", int'(bus.busy), 0);
    check("mid-frame reset fifo_count", int'(bus.fifo_count), 0);
    check("mid-frame reset overflow", int'(bus.overflow), 0);
    exp_q.delete();
    ovf_exp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    quiet_cycles("no frame after reset release", 200);
    drive_burst(gen(3), c);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1, "watchdog");
  end
endmodule
